// File: rtl/mixer_pdm.sv
// Time-multiplexed NCH-channel audio mixer: per-channel volume and pan, frame
// accumulation into left/right levels, and a first-order sigma-delta 1-bit DAC per side.
module mixer_pdm #(
   parameter  int NCH = 8,
   parameter  int DW  = 8,
   parameter  int VW  = 4,
   localparam int AW  = DW + VW + $clog2(NCH)
) (
   input  logic              clk28,
   input  logic              rst,
   input  logic [NCH*DW-1:0] ch_data,
   input  logic [NCH*VW-1:0] ch_vol,
   input  logic [NCH*2-1:0]  ch_pan,
   input  logic              mono,
   output logic              frame_stb,
   output logic [AW-1:0]     level_l,
   output logic [AW-1:0]     level_r,
   output logic              dac_l,
   output logic              dac_r
);

   localparam int IW = $clog2(NCH);
   localparam int PW = DW + VW;

   logic [DW-1:0] data_a [NCH];
   logic [VW-1:0] vol_a  [NCH];
   logic [1:0]    pan_a  [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign data_a[g] = ch_data[g*DW +: DW];
      assign vol_a[g]  = ch_vol[g*VW +: VW];
      assign pan_a[g]  = ch_pan[g*2 +: 2];
   end

   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [AW-1:0] lvl_l_q, lvl_l_d, lvl_r_q, lvl_r_d;
   logic          stb_q, stb_d;
   logic [AW:0]   cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;

   logic [PW-1:0] prod;
   logic [AW-1:0] pl, pr, raw_l, raw_r;
   logic [AW:0]   sum_m;
   logic          last;

   // Only the scanned channel's inputs reach the datapath this cycle.
   assign prod  = {{VW{1'b0}}, data_a[idx_q]} * {{DW{1'b0}}, vol_a[idx_q]};
   assign pl    = pan_a[idx_q][0] ? {{(AW-PW){1'b0}}, prod} : '0;
   assign pr    = pan_a[idx_q][1] ? {{(AW-PW){1'b0}}, prod} : '0;
   assign raw_l = acc_l_q + pl;
   assign raw_r = acc_r_q + pr;
   assign sum_m = {1'b0, raw_l} + {1'b0, raw_r};
   assign last  = (idx_q == IW'(NCH-1));

   always_comb begin
      idx_d   = idx_q + IW'(1);
      acc_l_d = raw_l;
      acc_r_d = raw_r;
      lvl_l_d = lvl_l_q;
      lvl_r_d = lvl_r_q;
      stb_d   = 1'b0;
      if (last) begin
         idx_d   = '0;
         acc_l_d = '0;
         acc_r_d = '0;
         stb_d   = 1'b1;
         if (mono) begin
            lvl_l_d = sum_m[AW:1];
            lvl_r_d = sum_m[AW:1];
         end else begin
            lvl_l_d = raw_l;
            lvl_r_d = raw_r;
         end
      end
      // Carry out of the low AW bits is the PDM bit; it averages to level/2^AW.
      cnt_l_d = {1'b0, cnt_l_q[AW-1:0]} + {1'b0, lvl_l_q};
      cnt_r_d = {1'b0, cnt_r_q[AW-1:0]} + {1'b0, lvl_r_q};
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         idx_q   <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         lvl_l_q <= '0;
         lvl_r_q <= '0;
         stb_q   <= 1'b0;
         cnt_l_q <= '0;
         cnt_r_q <= '0;
      end else begin
         idx_q   <= idx_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         lvl_l_q <= lvl_l_d;
         lvl_r_q <= lvl_r_d;
         stb_q   <= stb_d;
         cnt_l_q <= cnt_l_d;
         cnt_r_q <= cnt_r_d;
      end
   end

   assign frame_stb = stb_q;
   assign level_l   = lvl_l_q;
   assign level_r   = lvl_r_q;
   assign dac_l     = cnt_l_q[AW];
   assign dac_r     = cnt_r_q[AW];

endmodule

// File: tb/tb_mixer_pdm.sv
// Bench for mixer_pdm: a 2-channel and an 8-channel instance, directed steps with
// expected frame levels queued when stimulus is applied and checked at frame_stb.
module tb_mixer_pdm;

   localparam int DW  = 8;
   localparam int VW  = 4;
   localparam int NA  = 2;
   localparam int AWA = 13;
   localparam int NB  = 8;
   localparam int AWB = 15;

   typedef struct {
      int l;
      int r;
   } exp_t;

   logic clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   logic              rst_a, mono_a, stb_a, dac_l_a, dac_r_a;
   logic [NA*DW-1:0]  data_a;
   logic [NA*VW-1:0]  vol_a;
   logic [NA*2-1:0]   pan_a;
   logic [AWA-1:0]    lvl_l_a, lvl_r_a;

   logic              rst_b, mono_b, stb_b, dac_l_b, dac_r_b;
   logic [NB*DW-1:0]  data_b;
   logic [NB*VW-1:0]  vol_b;
   logic [NB*2-1:0]   pan_b;
   logic [AWB-1:0]    lvl_l_b, lvl_r_b;

   mixer_pdm #(.NCH(NA), .DW(DW), .VW(VW)) u_a (
      .clk28(clk28), .rst(rst_a), .ch_data(data_a), .ch_vol(vol_a), .ch_pan(pan_a),
      .mono(mono_a), .frame_stb(stb_a), .level_l(lvl_l_a), .level_r(lvl_r_a),
      .dac_l(dac_l_a), .dac_r(dac_r_a));

   mixer_pdm #(.NCH(NB), .DW(DW), .VW(VW)) u_b (
      .clk28(clk28), .rst(rst_b), .ch_data(data_b), .ch_vol(vol_b), .ch_pan(pan_b),
      .mono(mono_b), .frame_stb(stb_b), .level_l(lvl_l_b), .level_r(lvl_r_b),
      .dac_l(dac_l_b), .dac_r(dac_r_b));

   int   tests = 0;
   int   fails = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   db[NB];
   int   vb[NB];
   int   pb[NB];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic set_a(input int ch, input int d, input int v, input int p);
      data_a[ch*DW +: DW] = DW'(d);
      vol_a[ch*VW +: VW]  = VW'(v);
      pan_a[ch*2 +: 2]    = 2'(p);
   endtask

   task automatic apply_b();
      for (int k = 0; k < NB; k++) begin
         data_b[k*DW +: DW] = DW'(db[k]);
         vol_b[k*VW +: VW]  = VW'(vb[k]);
         pan_b[k*2 +: 2]    = 2'(pb[k]);
      end
   endtask

   // Reference frame sum for the 8-channel instance from the bench's own tables.
   function automatic exp_t ref_b(input bit m);
      exp_t e;
      int   p;
      e.l = 0;
      e.r = 0;
      for (int k = 0; k < NB; k++) begin
         p = db[k] * vb[k];
         if (pb[k] & 1) e.l += p;
         if (pb[k] & 2) e.r += p;
      end
      if (m) begin
         e.l = (e.l + e.r) >> 1;
         e.r = e.l;
      end
      return e;
   endfunction

   task automatic push_a(input int l, input int r);
      exp_t e;
      e.l = l;
      e.r = r;
      q_a.push_back(e);
   endtask

   // Waits (bounded) for frame_stb; the cycle count is compared against expn.
   task automatic frame_a(input string tag, input int expn);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk28);
         n++;
      end while (!stb_a && n < 64);
      chk({tag, " period"}, n, expn);
      e = q_a.pop_front();
      chk({tag, " L"}, lvl_l_a, e.l);
      chk({tag, " R"}, lvl_r_a, e.r);
   endtask

   task automatic frame_b(input string tag, input int expn);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk28);
         n++;
      end while (!stb_b && n < 64);
      chk({tag, " period"}, n, expn);
      e = q_b.pop_front();
      chk({tag, " L"}, lvl_l_b, e.l);
      chk({tag, " R"}, lvl_r_b, e.r);
   endtask

   task automatic sync_a();
      int n;
      n = 0;
      do begin
         @(negedge clk28);
         n++;
      end while (!stb_a && n < 64);
      chk("sync_a stb", stb_a, 1);
   endtask

   task automatic sync_b();
      int n;
      n = 0;
      do begin
         @(negedge clk28);
         n++;
      end while (!stb_b && n < 64);
      chk("sync_b stb", stb_b, 1);
   endtask

   task automatic count_dac_a(input int cycles, output int ol, output int orr);
      ol  = 0;
      orr = 0;
      repeat (cycles) begin
         @(negedge clk28);
         ol  += int'(dac_l_a);
         orr += int'(dac_r_a);
      end
   endtask

   initial begin
      int ol, orr;
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      mono_a = 1'b0;
      mono_b = 1'b0;
      data_a = '0;
      vol_a  = '0;
      pan_a  = '0;
      data_b = '0;
      vol_b  = '0;
      pan_b  = '0;

      // Reset state
      repeat (3) @(negedge clk28);
      chk("rst stb_a", stb_a, 0);
      chk("rst lvl_l_a", lvl_l_a, 0);
      chk("rst lvl_r_a", lvl_r_a, 0);
      chk("rst dac_l_a", dac_l_a, 0);
      chk("rst dac_r_a", dac_r_a, 0);
      chk("rst stb_b", stb_b, 0);
      chk("rst lvl_l_b", lvl_l_b, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk28);
      chk("first stb cyc1", stb_a, 0);
      @(negedge clk28);
      chk("first stb cyc2", stb_a, 1);

      // Silent sources: zero levels and a DAC stuck at 0
      set_a(0, 0, 15, 3);
      set_a(1, 0, 15, 3);
      push_a(0, 0);
      frame_a("zero", 2);
      count_dac_a(10000, ol, orr);
      chk("zero dac_l ones", ol, 0);
      chk("zero dac_r ones", orr, 0);

      // Left-only full-scale channel 0, channel 1 muted by volume
      sync_a();
      set_a(0, 255, 15, 1);
      set_a(1, 255, 0, 3);
      push_a(3825, 0);
      frame_a("left", 2);
      count_dac_a(8192, ol, orr);
      chk("left dac_l ones", ol, 3825);
      chk("left dac_r ones", orr, 0);

      // Both channels full-scale to both sides, then a volume change on channel 0
      sync_a();
      set_a(0, 255, 15, 3);
      set_a(1, 255, 15, 3);
      push_a(7650, 7650);
      frame_a("both", 2);
      count_dac_a(8192, ol, orr);
      chk("both dac_l ones", ol, 7650);
      chk("both dac_r ones", orr, 7650);
      sync_a();
      set_a(0, 255, 8, 3);
      push_a(5865, 5865);
      frame_a("vol8", 2);

      // Mono fold, and mono sampled only at end of frame
      set_a(0, 255, 15, 1);
      set_a(1, 255, 0, 3);
      mono_a = 1'b1;
      push_a(1912, 1912);
      frame_a("mono", 2);
      mono_a = 1'b0;
      @(negedge clk28);
      mono_a = 1'b1;
      push_a(1912, 1912);
      frame_a("mono hold", 1);
      chk("mono toggle now", lvl_l_a, 1912);
      @(negedge clk28);
      mono_a = 1'b0;
      push_a(3825, 0);
      frame_a("stereo back", 1);

      // 8-channel ramp with mixed pan routing
      sync_b();
      for (int k = 0; k < NB; k++) begin
         db[k] = 16 * k + 15;
         vb[k] = k + 3;
         pb[k] = k % 4;
      end
      apply_b();
      q_b.push_back(ref_b(1'b0));
      frame_b("ramp", 8);
      mono_b = 1'b1;
      q_b.push_back(ref_b(1'b1));
      frame_b("ramp mono", 8);
      mono_b = 1'b0;
      for (int k = 0; k < NB; k++) begin
         vb[k] = 15 - k;
         pb[k] = 3 - (k % 4);
      end
      apply_b();
      q_b.push_back(ref_b(1'b0));
      frame_b("ramp2", 8);

      // Reset while channel 4 is being scanned: partial frame discarded
      repeat (4) @(negedge clk28);
      rst_b = 1'b1;
      @(negedge clk28);
      chk("midrst lvl_l_b", lvl_l_b, 0);
      chk("midrst lvl_r_b", lvl_r_b, 0);
      chk("midrst stb_b", stb_b, 0);
      chk("midrst dac_l_b", dac_l_b, 0);
      rst_b = 1'b0;
      repeat (4) @(negedge clk28);
      chk("postrst lvl_l_b", lvl_l_b, 0);
      chk("postrst stb_b", stb_b, 0);
      q_b.push_back(ref_b(1'b0));
      frame_b("postrst f1", 4);
      q_b.push_back(ref_b(1'b0));
      frame_b("postrst f2", 8);
      q_b.push_back(ref_b(1'b0));
      frame_b("postrst f3", 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
